// File: rtl/dec_ascii_writer.sv
// Serialises signed words as ASCII decimal text: [sign] digits terminator, one char per handshake.
// Define DEC_ASCII_WRITER_PLUS_EN to prefix non-negative values with '+'.
module dec_ascii_writer #(
  parameter int          WIDTH     = 32,
  parameter int          NDIG      = 10,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [2:0] {IDLE, CONVERT, EMIT_SIGN, EMIT_DIG, EMIT_TERM} state_t;
  state_t state, state_nxt;

  logic                     neg;
  logic [WIDTH-1:0]         mag, mag_in;
  logic [NDIG-1:0][3:0]     bcd, adj, bcd_sh;
  logic [NDIG*4-1:0]        adj_flat;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx, idx_top;

  // |in_data|; the most negative value wraps onto 2^(WIDTH-1), which is correct as unsigned
  assign mag_in = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    assign adj[g] = (bcd[g] >= 4'd5) ? bcd[g] + 4'd3 : bcd[g];
  end
  assign adj_flat = adj;
  assign bcd_sh   = {adj_flat[NDIG*4-2:0], mag[WIDTH-1]};

  // highest non-zero digit of the final shift result; 0 when the value is zero
  always_comb begin
    idx_top = '0;
    for (int i = 0; i < NDIG; i++)
      if (bcd_sh[i] != 4'd0) idx_top = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      neg   <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          neg <= in_data[WIDTH-1];
          mag <= mag_in;
          bcd <= '0;
          cnt <= CW'(WIDTH);
        end
        CONVERT: begin
          bcd <= bcd_sh;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) idx <= idx_top;
        end
        EMIT_DIG: if (out_ready && idx != '0) idx <= idx - IW'(1);
        default: ;
      endcase
    end
  end

  // outputs are decoded from registered state only, so they hold while stalled
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_char  = 8'h00;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONVERT;
      end
      CONVERT: if (cnt == CW'(1)) begin
`ifdef DEC_ASCII_WRITER_PLUS_EN
        state_nxt = EMIT_SIGN;
`else
        state_nxt = neg ? EMIT_SIGN : EMIT_DIG;
`endif
      end
      EMIT_SIGN: begin
        out_valid = 1'b1;
`ifdef DEC_ASCII_WRITER_PLUS_EN
        out_char  = neg ? 8'h2D : 8'h2B;
`else
        out_char  = 8'h2D;
`endif
        if (out_ready) state_nxt = EMIT_DIG;
      end
      EMIT_DIG: begin
        out_valid = 1'b1;
        out_char  = 8'h30 + {4'h0, bcd[idx]};
        if (out_ready && idx == '0) state_nxt = EMIT_TERM;
      end
      EMIT_TERM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_char  = TERM_CHAR;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dec_ascii_writer.sv
// Directed bench for dec_ascii_writer; checks latency, text, handshakes, stalls and reset.
module tb_dec_ascii_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  out_char;

  int total = 0;
  int bad   = 0;

  dec_ascii_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic string pfx(input string s, input bit is_neg);
`ifdef DEC_ASCII_WRITER_PLUS_EN
    return is_neg ? s : {"+", s};
`else
    return s;
`endif
  endfunction

  // present one word, then wait for the first out_valid; lat counts cycles after the accept edge
  task automatic send(input logic [31:0] v, output int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1; in_data = v;
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  // drain one word starting at the current negedge; bp selects the 1,0,0 ready pattern
  task automatic recv(input string s, input bit bp, output int cyc);
    int k = 0;
    bit held = 0;
    logic [7:0] hc = 8'h00;
    logic rdy;
    cyc = 0;
    while (k < s.len() && cyc < 200) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (held) check("stall_hold", out_char, hc);
        check("in_ready_low_busy", in_ready, 0);
        if (rdy) begin
          check($sformatf("char%0d", k), out_char, s[k]);
          check($sformatf("last%0d", k), out_last, k == s.len() - 1);
          k++;
          held = 0;
        end else begin
          held = 1;
          hc = out_char;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check("recv_complete", k, s.len());
    out_ready = 1'b0;
    check("in_ready_after_term", in_ready, 1);
    check("out_valid_after_term", out_valid, 0);
  endtask

  initial begin
    int lat, cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_char", out_char, 8'h00);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero, with latency check
    send(32'd0, lat);
    check("lat_zero", lat, 33);
    recv(pfx("0\n", 0), 0, cyc);

    // 1234 on consecutive cycles
    send(32'd1234, lat);
    check("lat_1234", lat, 33);
    recv(pfx("1234\n", 0), 0, cyc);
    check("cyc_1234", cyc, pfx("1234\n", 0).len());

    send(-32'sd5, lat);
    recv("-5\n", 0, cyc);
    send(32'd7, lat);
    recv(pfx("7\n", 0), 0, cyc);

    // back to back with in_valid held; data change after accept must be ignored
    in_valid = 1'b1; in_data = 32'h8000_0000;
    @(negedge clk);
    in_data = 32'h7FFF_FFFF;
    check("busy_convert", busy, 1);
    check("in_ready_convert", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("lat_min", lat, 33);
    recv("-2147483648\n", 0, cyc);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("lat_max", lat, 33);
    recv(pfx("2147483647\n", 0), 0, cyc);

    // backpressure
    send(32'd42, lat);
    recv(pfx("42\n", 0), 1, cyc);

    // reset in the middle of emitting 1234
    send(32'd1234, lat);
    out_ready = 1'b1;
`ifdef DEC_ASCII_WRITER_PLUS_EN
    check("mid_plus", out_char, 8'h2B);
    @(negedge clk);
`endif
    check("mid_first", out_char, 8'h31);
    @(negedge clk);
    check("mid_second", out_char, 8'h32);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_char", out_char, 8'h00);
    send(32'd9, lat);
    check("lat_9", lat, 33);
    recv(pfx("9\n", 0), 0, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
